// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: pipeline memory stage with byte-enabled data RAM, wait states and fault reporting
module mem_stage_lsu #(
    parameter int DEPTH = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        ValidW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic        FaultW
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0, WAIT = 1'b1;
    logic [0:0]  st;
    logic [3:0]  cnt;
    logic [2:0]  l_f3, a_f3;
    logic [31:0] l_addr, l_wd, l_pc, a_addr, a_wd, a_pc;
    logic [4:0]  l_rd, a_rd;
    logic        l_wr, a_wr;
    logic [31:0] ram [DEPTH];
    logic        in_wait, ill_enc, mis, go, fault, stall, done;
    logic [AW-1:0] idx;
    logic [31:0] word, ld, wdat;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  be;

    assign in_wait = st == WAIT;
    assign ill_enc = MemReadM ? (Funct3M == 3'b011 || Funct3M[2:1] == 2'b11) : (MemWriteM && Funct3M > 3'b010);
    assign mis = (Funct3M[1:0] == 2'b01 && ALUResultM[0]) || (Funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
    assign go = ValidM && (MemReadM ^ MemWriteM) && !ill_enc && !mis;
    assign fault = ValidM && (MemReadM || MemWriteM) && !go;
    assign stall = rst && (in_wait ? cnt > 4'd1 : go && WAIT_STATES > 0);
    assign done = rst && (in_wait ? cnt == 4'd1 : go && WAIT_STATES == 0);
    assign StallM = stall;
    // While waiting, the access is driven entirely from the latched copies
    assign a_f3 = in_wait ? l_f3 : Funct3M;
    assign a_addr = in_wait ? l_addr : ALUResultM;
    assign a_wd = in_wait ? l_wd : WriteDataM;
    assign a_rd = in_wait ? l_rd : RdM;
    assign a_pc = in_wait ? l_pc : PCPlus4M;
    assign a_wr = in_wait ? l_wr : MemWriteM;
    assign idx = a_addr[AW+1:2];
    assign word = ram[idx];
    assign b = 8'(word >> {a_addr[1:0], 3'b000});
    assign h = a_addr[1] ? word[31:16] : word[15:0];
    assign ld = a_f3[1:0] == 2'b00 ? {{24{!a_f3[2] && b[7]}}, b} :
                a_f3[1:0] == 2'b01 ? {{16{!a_f3[2] && h[15]}}, h} : word;
    assign be = a_f3[1:0] == 2'b00 ? 4'b0001 << a_addr[1:0] :
                a_f3[1:0] == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdat = a_f3[1:0] == 2'b00 ? {4{a_wd[7:0]}} :
                  a_f3[1:0] == 2'b01 ? {2{a_wd[15:0]}} : a_wd;

    always_ff @(posedge clk) begin
        if (done && a_wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[idx][8*i +: 8] <= wdat[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st <= IDLE;
            cnt <= 4'd0;
            ValidW <= 1'b0;
            FaultW <= 1'b0;
            RdW <= 5'd0;
            PCPlus4W <= 32'd0;
            ALUResultW <= 32'd0;
            ReadDataW <= 32'd0;
        end else begin
            if (in_wait) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) st <= IDLE;
            end else if (stall) begin
                st <= WAIT;
                cnt <= 4'(WAIT_STATES);
                l_f3 <= Funct3M;
                l_addr <= ALUResultM;
                l_wd <= WriteDataM;
                l_rd <= RdM;
                l_pc <= PCPlus4M;
                l_wr <= MemWriteM;
            end
            if (stall) begin
                ValidW <= 1'b0;
                FaultW <= 1'b0;
            end else begin
                ValidW <= in_wait || ValidM;
                FaultW <= !in_wait && fault;
                RdW <= a_rd;
                PCPlus4W <= a_pc;
                ALUResultW <= a_addr;
                ReadDataW <= done && !a_wr ? ld : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of mem_stage_lsu with zero and three wait states
module tb_mem_stage_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ValidM = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0] Funct3M = 3'd0;
    logic [4:0] RdM = 5'd0;
    logic [31:0] PCPlus4M = 32'd0, ALUResultM = 32'd0, WriteDataM = 32'd0;
    logic stall0, validw0, faultw0, stall3, validw3, faultw3;
    logic [4:0] rdw0, rdw3;
    logic [31:0] pcw0, aluw0, rdataw0, pcw3, aluw3, rdataw3;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DEPTH(64), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .ValidM(ValidM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .RdM(RdM), .PCPlus4M(PCPlus4M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .StallM(stall0), .ValidW(validw0), .RdW(rdw0),
        .PCPlus4W(pcw0), .ALUResultW(aluw0), .ReadDataW(rdataw0), .FaultW(faultw0)
    );

    mem_stage_lsu #(.DEPTH(64), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .ValidM(ValidM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .RdM(RdM), .PCPlus4M(PCPlus4M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .StallM(stall3), .ValidW(validw3), .RdW(rdw3),
        .PCPlus4W(pcw3), .ALUResultW(aluw3), .ReadDataW(rdataw3), .FaultW(faultw3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc);
        ValidM = v; MemReadM = r; MemWriteM = w; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_checks++; if (stall0 !== 1'b0 || stall3 !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b/%b exp 0/0", stall0, stall3); end
        n_checks++; if ({validw0, faultw0, rdw0, pcw0, aluw0, rdataw0} !== '0) begin n_fail++; $display("FAIL reset_w0 got v%b f%b rd%h pc%h alu%h rdata%h exp all 0", validw0, faultw0, rdw0, pcw0, aluw0, rdataw0); end
        n_checks++; if ({validw3, faultw3, rdw3, pcw3, aluw3, rdataw3} !== '0) begin n_fail++; $display("FAIL reset_w3 got v%b f%b rd%h pc%h alu%h rdata%h exp all 0", validw3, faultw3, rdw3, pcw3, aluw3, rdataw3); end
        rst = 1'b1;
    endtask

    task automatic test_word_ws0();
        drive(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 32'h104);
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL sw_stall got %b exp 0", stall0); end
        tick();
        n_checks++; if (validw0 !== 1'b1 || faultw0 !== 1'b0 || rdataw0 !== 32'h0) begin n_fail++; $display("FAIL sw_w got v%b f%b rdata%h exp v1 f0 rdata0", validw0, faultw0, rdataw0); end
        drive(1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd2, 32'h108);
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL lw_stall got %b exp 0", stall0); end
        tick();
        n_checks++; if (validw0 !== 1'b1 || rdataw0 !== 32'hDEADBEEF || rdw0 !== 5'd2 || pcw0 !== 32'h108) begin n_fail++; $display("FAIL lw_word got v%b rdata%h rd%h pc%h exp v1 deadbeef 02 108", validw0, rdataw0, rdw0, pcw0); end
    endtask

    task automatic test_subword();
        drive(1, 0, 1, 3'b010, 32'h20, 32'h80FF7F01, 5'd0, 32'h0);
        tick();
        drive(1, 1, 0, 3'b000, 32'h23, 32'h0, 5'd3, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got %h exp ffffff80", rdataw0); end
        drive(1, 1, 0, 3'b100, 32'h23, 32'h0, 5'd3, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h exp 00000080", rdataw0); end
        drive(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd3, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh got %h exp ffff80ff", rdataw0); end
        drive(1, 1, 0, 3'b101, 32'h20, 32'h0, 5'd3, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'h00007F01) begin n_fail++; $display("FAIL lhu got %h exp 00007f01", rdataw0); end
        drive(1, 0, 1, 3'b000, 32'h21, 32'h123456AA, 5'd0, 32'h0); tick();
        drive(1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd3, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'h80FFAA01) begin n_fail++; $display("FAIL sb_lw got %h exp 80ffaa01", rdataw0); end
        drive(1, 0, 1, 3'b001, 32'h22, 32'hFFFF1234, 5'd0, 32'h0); tick();
        drive(1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd3, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'h1234AA01) begin n_fail++; $display("FAIL sh_lw got %h exp 1234aa01", rdataw0); end
    endtask

    task automatic test_fault();
        drive(1, 0, 1, 3'b010, 32'h12, 32'h11223344, 5'd4, 32'h0);
        n_checks++; if (stall0 !== 1'b0 || stall3 !== 1'b0) begin n_fail++; $display("FAIL missw_stall got %b/%b exp 0/0", stall0, stall3); end
        tick();
        n_checks++; if (faultw0 !== 1'b1 || validw0 !== 1'b1 || aluw0 !== 32'h12 || rdataw0 !== 32'h0) begin n_fail++; $display("FAIL missw got f%b v%b alu%h rdata%h exp f1 v1 12 0", faultw0, validw0, aluw0, rdataw0); end
        drive(1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd4, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'hDEADBEEF || faultw0 !== 1'b0) begin n_fail++; $display("FAIL missw_readback got %h f%b exp deadbeef f0", rdataw0, faultw0); end
        drive(1, 1, 0, 3'b001, 32'h05, 32'h0, 5'd4, 32'h0); tick();
        n_checks++; if (faultw0 !== 1'b1 || rdataw0 !== 32'h0) begin n_fail++; $display("FAIL mislh got f%b rdata%h exp f1 0", faultw0, rdataw0); end
        drive(1, 1, 0, 3'b011, 32'h10, 32'h0, 5'd4, 32'h0); tick();
        n_checks++; if (faultw0 !== 1'b1 || rdataw0 !== 32'h0) begin n_fail++; $display("FAIL ill_f3 got f%b rdata%h exp f1 0", faultw0, rdataw0); end
    endtask

    task automatic test_wrap_illegal();
        drive(1, 0, 1, 3'b010, 32'h100, 32'hCAFEF00D, 5'd0, 32'h0); tick();
        drive(1, 1, 0, 3'b010, 32'h000, 32'h0, 5'd5, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap got %h exp cafef00d", rdataw0); end
        drive(1, 1, 1, 3'b010, 32'h000, 32'h12345678, 5'd5, 32'h0); tick();
        n_checks++; if (faultw0 !== 1'b1 || validw0 !== 1'b1 || rdataw0 !== 32'h0) begin n_fail++; $display("FAIL rw_both got f%b v%b rdata%h exp f1 v1 0", faultw0, validw0, rdataw0); end
        drive(1, 1, 0, 3'b010, 32'h000, 32'h0, 5'd5, 32'h0); tick();
        n_checks++; if (rdataw0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rw_both_nowrite got %h exp cafef00d", rdataw0); end
        drive(1, 0, 0, 3'b010, 32'h99, 32'h0, 5'd7, 32'h44); tick();
        n_checks++; if (validw0 !== 1'b1 || faultw0 !== 1'b0 || rdataw0 !== 32'h0 || rdw0 !== 5'd7 || pcw0 !== 32'h44 || aluw0 !== 32'h99) begin n_fail++; $display("FAIL plain got v%b f%b rdata%h rd%h pc%h alu%h exp v1 f0 0 07 44 99", validw0, faultw0, rdataw0, rdw0, pcw0, aluw0); end
        drive(0, 1, 1, 3'b111, 32'h3, 32'h0, 5'd7, 32'h44); tick();
        n_checks++; if (validw0 !== 1'b0 || faultw0 !== 1'b0) begin n_fail++; $display("FAIL novalid got v%b f%b exp v0 f0", validw0, faultw0); end
    endtask

    task automatic test_wait3();
        idle(6);
        drive(1, 0, 1, 3'b010, 32'h40, 32'h5555AAAA, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (validw3 !== 1'b1 || rdataw3 !== 32'h0) begin n_fail++; $display("FAIL w3_sw got v%b rdata%h exp v1 0", validw3, rdataw3); end
        drive(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd9, 32'h200);
        n_checks++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL w3_stall_t got %b exp 1", stall3); end
        tick();
        n_checks++; if (validw3 !== 1'b0) begin n_fail++; $display("FAIL w3_valid_t got %b exp 0", validw3); end
        drive(1, 0, 1, 3'b010, 32'h40, 32'hFFFFFFFF, 5'd1, 32'h300);
        for (int i = 1; i < 3; i++) begin
            n_checks++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL w3_stall_t%0d got %b exp 1", i, stall3); end
            tick();
            n_checks++; if (validw3 !== 1'b0) begin n_fail++; $display("FAIL w3_valid_t%0d got %b exp 0", i, validw3); end
        end
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL w3_stall_t3 got %b exp 0", stall3); end
        tick();
        n_checks++; if (validw3 !== 1'b1 || rdataw3 !== 32'h5555AAAA || rdw3 !== 5'd9 || pcw3 !== 32'h200 || faultw3 !== 1'b0) begin n_fail++; $display("FAIL w3_lw got v%b rdata%h rd%h pc%h f%b exp v1 5555aaaa 09 200 f0", validw3, rdataw3, rdw3, pcw3, faultw3); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 1, 3'b010, 32'h40, 32'h0BADF00D, 5'd3, 32'h400);
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b exp 0", stall3); end
        tick();
        n_checks++; if ({validw3, faultw3, rdw3, pcw3, aluw3, rdataw3} !== '0) begin n_fail++; $display("FAIL rstmid_w got v%b f%b rd%h pc%h alu%h rdata%h exp all 0", validw3, faultw3, rdw3, pcw3, aluw3, rdataw3); end
        rst = 1'b1;
        idle(1);
        drive(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd6, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (validw3 !== 1'b1 || rdataw3 !== 32'h5555AAAA) begin n_fail++; $display("FAIL rstmid_readback got v%b %h exp v1 5555aaaa", validw3, rdataw3); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        drive(1, 0, 1, 3'b010, 32'h44, 32'h13579BDF, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            stalls += int'(stall3);
            tick();
        end
        n_checks++; if (stalls != 3 || validw3 !== 1'b1) begin n_fail++; $display("FAIL b2b_sw got stalls %0d v%b exp 3 v1", stalls, validw3); end
        drive(1, 1, 0, 3'b010, 32'h44, 32'h0, 5'd8, 32'h0);
        n_checks++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b exp 1", stall3); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (validw3 !== 1'b1 || rdataw3 !== 32'h13579BDF || rdw3 !== 5'd8) begin n_fail++; $display("FAIL b2b_lw got v%b %h rd%h exp v1 13579bdf 08", validw3, rdataw3, rdw3); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_word_ws0();
        test_subword();
        test_fault();
        test_wrap_illegal();
        test_wait3();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
